// File: rtl/mem_bus_decoder_if.sv
// mem_bus_decoder_if: picorv32 native memory bus between the CPU (master)
// and the address decoder (slave).
//
// Handshake: the master raises mem_valid with mem_addr/mem_wdata/mem_wstrb
// stable and keeps them there until the slave answers. The slave answers
// each accepted request with exactly one single-cycle mem_ready pulse;
// mem_rdata is meaningful only while mem_ready=1. mem_wstrb=0 is a read,
// any other value is a write with per-byte enables.
interface mem_bus_decoder_if;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bus_decoder.sv
// mem_bus_decoder: routes picorv32 memory requests to on-chip SRAM or to a
// 256-byte MMIO slot; anything else completes with ERR_WORD and raises a
// sticky bus_err that remembers the first failing address.
//
// Optional build macro BUS_TIMEOUT_EN: when defined, an MMIO access that
// sees no io_ready for TIMEOUT_CYCLES cycles is abandoned and completed as
// an error. When undefined, MMIO accesses wait for io_ready indefinitely.
//
// All outputs are registered. dbg_state exposes the FSM state
// (0 IDLE, 1 SRAM_WAIT, 2 IO_WAIT, 3 RESP).
module mem_bus_decoder #(
    parameter int unsigned SRAM_ADDRWIDTH = 13,
    parameter logic [31:0] IO_BASE        = 32'h1000_0000,
    parameter logic [31:0] ERR_WORD       = 32'hDEAD_BEEF,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    mem_bus_decoder_if.slave          cpu,
    output logic                      sram_sel,
    output logic [3:0]                sram_wstrb,
    output logic [SRAM_ADDRWIDTH-1:0] sram_addr,
    output logic [31:0]               sram_wdata,
    input  logic                      sram_ready,
    input  logic [31:0]               sram_rdata,
    output logic                      io_sel,
    output logic [3:0]                io_wstrb,
    output logic [7:0]                io_addr,
    output logic [31:0]               io_wdata,
    input  logic                      io_ready,
    input  logic [31:0]               io_rdata,
    output logic                      bus_err,
    output logic [31:0]               err_addr,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SRAM_WAIT = 2'd1,
        IO_WAIT   = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t state;

    // Unmapped accesses spend two cycles in RESP: the first with mem_ready
    // low, the second with the pulse, so the CPU sees them two clocks after
    // the request is accepted.
    logic err_hold;

    logic sram_hit;
    logic io_hit;

`ifdef BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] io_cnt;
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    // Address decode of the request currently on the CPU bus.
    assign sram_hit = (cpu.mem_addr[31:SRAM_ADDRWIDTH] == '0);
    assign io_hit   = (cpu.mem_addr[31:8] == IO_BASE[31:8]);

    assign dbg_state = state;

    // Request FSM: decode in IDLE, wait for the selected target, then pulse
    // mem_ready for one cycle in RESP. RESP also soaks up the stale
    // sram_ready that trails a deselect.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            err_hold       <= 1'b0;
            cpu.mem_ready  <= 1'b0;
            cpu.mem_rdata  <= '0;
            sram_sel       <= 1'b0;
            sram_wstrb     <= '0;
            sram_addr      <= '0;
            sram_wdata     <= '0;
            io_sel         <= 1'b0;
            io_wstrb       <= '0;
            io_addr        <= '0;
            io_wdata       <= '0;
            bus_err        <= 1'b0;
            err_addr       <= '0;
`ifdef BUS_TIMEOUT_EN
            io_cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    cpu.mem_ready <= 1'b0;
                    if (cpu.mem_valid) begin
                        if (sram_hit) begin
                            sram_sel   <= 1'b1;
                            sram_addr  <= cpu.mem_addr[SRAM_ADDRWIDTH-1:0];
                            sram_wdata <= cpu.mem_wdata;
                            sram_wstrb <= cpu.mem_wstrb;
                            state      <= SRAM_WAIT;
                        end else if (io_hit) begin
                            io_sel   <= 1'b1;
                            io_addr  <= cpu.mem_addr[7:0];
                            io_wdata <= cpu.mem_wdata;
                            io_wstrb <= cpu.mem_wstrb;
`ifdef BUS_TIMEOUT_EN
                            io_cnt   <= '0;
`endif
                            state    <= IO_WAIT;
                        end else begin
                            cpu.mem_rdata <= ERR_WORD;
                            bus_err       <= 1'b1;
                            if (!bus_err) begin
                                err_addr <= cpu.mem_addr;
                            end
                            err_hold      <= 1'b1;
                            state         <= RESP;
                        end
                    end
                end

                SRAM_WAIT: begin
                    if (sram_ready) begin
                        cpu.mem_rdata <= sram_rdata;
                        cpu.mem_ready <= 1'b1;
                        sram_sel      <= 1'b0;
                        sram_wstrb    <= '0;
                        state         <= RESP;
                    end
                end

                IO_WAIT: begin
                    if (io_ready) begin
                        cpu.mem_rdata <= io_rdata;
                        cpu.mem_ready <= 1'b1;
                        io_sel        <= 1'b0;
                        io_wstrb      <= '0;
                        state         <= RESP;
                    end
`ifdef BUS_TIMEOUT_EN
                    else if (io_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        cpu.mem_rdata <= ERR_WORD;
                        cpu.mem_ready <= 1'b1;
                        io_sel        <= 1'b0;
                        io_wstrb      <= '0;
                        bus_err       <= 1'b1;
                        if (!bus_err) begin
                            err_addr <= {IO_BASE[31:8], io_addr};
                        end
                        state         <= RESP;
                    end else begin
                        io_cnt <= io_cnt + 1'b1;
                    end
`endif
                end

                RESP: begin
                    if (err_hold) begin
                        err_hold      <= 1'b0;
                        cpu.mem_ready <= 1'b1;
                    end else begin
                        cpu.mem_ready <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_decoder.sv
// tb_mem_bus_decoder: directed and randomized checks of mem_bus_decoder
// against a word-array reference model of the memory map.
module tb_mem_bus_decoder;

    localparam int          AW          = 13;
    localparam logic [31:0] ERR_W       = 32'hDEAD_BEEF;
    localparam int          TIMEOUT_CYC = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mem_bus_decoder_if bus();

    logic          sram_sel;
    logic [3:0]    sram_wstrb;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic          sram_ready;
    logic [31:0]   sram_rdata;
    logic          io_sel;
    logic [3:0]    io_wstrb;
    logic [7:0]    io_addr;
    logic [31:0]   io_wdata;
    logic          io_ready;
    logic [31:0]   io_rdata;
    logic          bus_err;
    logic [31:0]   err_addr;
    logic [1:0]    dbg_state;

    mem_bus_decoder dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu        (bus),
        .sram_sel   (sram_sel),
        .sram_wstrb (sram_wstrb),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_ready (sram_ready),
        .sram_rdata (sram_rdata),
        .io_sel     (io_sel),
        .io_wstrb   (io_wstrb),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_ready   (io_ready),
        .io_rdata   (io_rdata),
        .bus_err    (bus_err),
        .err_addr   (err_addr),
        .dbg_state  (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] st);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // ---------------- SRAM environment: 1-cycle registered ready ----------------
    logic [31:0] sram_mem [2048];
    always @(posedge clk) begin
        if (!resetn) sram_ready <= 1'b0;
        else         sram_ready <= sram_sel;
        if (resetn && sram_sel) begin
            sram_mem[sram_addr[12:2]] <= merge(sram_mem[sram_addr[12:2]], sram_wdata, sram_wstrb);
            sram_rdata <= merge(sram_mem[sram_addr[12:2]], sram_wdata, sram_wstrb);
        end
    end

    // ---------------- MMIO environment: answers io_delay_cfg cycles after io_sel ----------------
    int          io_delay_cfg = 0;
    logic [31:0] io_data_cfg  = '0;
    bit          io_stall     = 1'b0;
    initial begin
        io_ready = 1'b0;
        io_rdata = '0;
        forever begin
            @(posedge clk); #2;
            if (io_sel && !io_stall && resetn) begin
                repeat (io_delay_cfg) @(posedge clk);
                #2;
                io_ready = 1'b1;
                io_rdata = io_data_cfg;
                @(posedge clk); #2;
                io_ready = 1'b0;
            end
        end
    end

    // ---------------- reference model (memory map rules) ----------------
    logic [31:0] ref_mem [2048];
    logic        exp_bus_err  = 1'b0;
    logic [31:0] exp_err_addr = '0;
    logic [31:0] exp_q [$];

    // Predicts one access: expected read data, mem_ready latency in clocks
    // after the request is first driven, and whether data is meaningful.
    function automatic void model_access(input logic [31:0] addr, input logic [31:0] wd,
                                         input logic [3:0] st, input int io_delay,
                                         output logic [31:0] exp_rd, output int exp_lat,
                                         output bit chk_data);
        if (addr < 32'd8192) begin
            exp_lat  = 3;
            exp_rd   = ref_mem[addr / 4];
            chk_data = (st == 4'd0);
            ref_mem[addr / 4] = merge(ref_mem[addr / 4], wd, st);
        end else if (addr >= 32'h1000_0000 && addr <= 32'h1000_00FF) begin
            exp_lat  = 2 + io_delay;
            exp_rd   = io_data_cfg;
            chk_data = 1'b1;
        end else begin
            exp_lat  = 2;
            exp_rd   = ERR_W;
            chk_data = 1'b1;
            if (!exp_bus_err) exp_err_addr = addr;
            exp_bus_err = 1'b1;
        end
    endfunction

    // ---------------- driver ----------------
    logic          obs_sram_sel, obs_io_sel;
    logic [AW-1:0] obs_sram_addr;
    logic [3:0]    obs_sram_wstrb, obs_io_wstrb;
    logic [31:0]   obs_sram_wdata, obs_io_wdata;
    logic [7:0]    obs_io_addr;

    // Called #1 after a rising edge. Holds mem_valid until mem_ready unless
    // drop is set; returns latency (-1 on no answer) and whether mem_ready
    // was still high one cycle after the pulse.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] st,
                             input bit drop, output logic [31:0] rd, output int lat,
                             output logic ready_after);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = addr;
        bus.mem_wdata = wd;
        bus.mem_wstrb = st;
        lat = -1;
        rd  = 'x;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                obs_sram_sel   = sram_sel;
                obs_sram_addr  = sram_addr;
                obs_sram_wstrb = sram_wstrb;
                obs_sram_wdata = sram_wdata;
                obs_io_sel     = io_sel;
                obs_io_addr    = io_addr;
                obs_io_wstrb   = io_wstrb;
                obs_io_wdata   = io_wdata;
                if (drop) bus.mem_valid = 1'b0;
            end
            if (bus.mem_ready) begin
                lat = c;
                rd  = bus.mem_rdata;
                break;
            end
        end
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = '0;
        @(posedge clk); #1;
        ready_after = bus.mem_ready;
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        bus.mem_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        exp_bus_err  = 1'b0;
        exp_err_addr = '0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] f;
        apply_reset();
        f = {31'd0, bus.mem_ready | sram_sel | io_sel | bus_err};
        checks++;
        if ({bus.mem_ready, bus.mem_rdata, sram_sel, sram_wstrb, sram_addr, sram_wdata, io_sel,
             io_wstrb, io_addr, io_wdata, bus_err, err_addr, dbg_state} !== '0)
            begin errors++; $display("FAIL reset_outputs: flags=%h rdata=%h err_addr=%h state=%0d want all 0",
                                     f, bus.mem_rdata, err_addr, dbg_state); end
    endtask

    task automatic test_sram_write_read();
        logic [31:0] rd, exp_rd; int lat, exp_lat; logic ra; bit cd;
        model_access(32'h10, 32'hCAFE_BABE, 4'hF, 0, exp_rd, exp_lat, cd);
        do_access(32'h10, 32'hCAFE_BABE, 4'hF, 1'b0, rd, lat, ra);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL sram_wr_latency: got %0d want %0d", lat, exp_lat); end
        checks++; if (obs_sram_sel !== 1'b1 || obs_sram_addr !== 13'h010 || obs_sram_wstrb !== 4'hF || obs_sram_wdata !== 32'hCAFE_BABE)
            begin errors++; $display("FAIL sram_wr_drive: sel=%b addr=%h st=%h wd=%h want 1 010 f cafebabe", obs_sram_sel, obs_sram_addr, obs_sram_wstrb, obs_sram_wdata); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL sram_wr_pulse: ready after=%b want 0", ra); end
        model_access(32'h10, 32'h0, 4'h0, 0, exp_rd, exp_lat, cd);
        do_access(32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ra);
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL sram_rd_latency: got %0d want %0d", lat, exp_lat); end
        checks++; if (rd !== 32'hCAFE_BABE) begin errors++; $display("FAIL sram_rd_data: got %h want cafebabe", rd); end
        checks++; if (ra !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL sram_rd_pulse_err: ready after=%b bus_err=%b want 0 0", ra, bus_err); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd, exp_rd; int lat, exp_lat; logic ra; bit cd;
        model_access(32'h10, 32'h00AA_0000, 4'b0100, 0, exp_rd, exp_lat, cd);
        do_access(32'h10, 32'h00AA_0000, 4'b0100, 1'b0, rd, lat, ra);
        model_access(32'h10, 32'h0, 4'h0, 0, exp_rd, exp_lat, cd);
        do_access(32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ra);
        checks++; if (rd !== 32'hCAAA_BABE || exp_rd !== 32'hCAAA_BABE)
            begin errors++; $display("FAIL byte_write: got %h want caaababe", rd); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd, exp_rd; int lat, exp_lat; logic ra; bit cd;
        model_access(32'h2000_0000, 32'h0, 4'h0, 0, exp_rd, exp_lat, cd);
        do_access(32'h2000_0000, 32'h0, 4'h0, 1'b0, rd, lat, ra);
        checks++; if (lat !== 2) begin errors++; $display("FAIL unmapped_latency: got %0d want 2", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unmapped_data: got %h want deadbeef", rd); end
        checks++; if (bus_err !== 1'b1 || err_addr !== 32'h2000_0000)
            begin errors++; $display("FAIL unmapped_err: bus_err=%b err_addr=%h want 1 20000000", bus_err, err_addr); end
        checks++; if (ra !== 1'b0 || obs_sram_sel !== 1'b0 || obs_io_sel !== 1'b0)
            begin errors++; $display("FAIL unmapped_sel: ready after=%b sram_sel=%b io_sel=%b want 0 0 0", ra, obs_sram_sel, obs_io_sel); end
        model_access(32'h3000_0000, 32'h0, 4'h0, 0, exp_rd, exp_lat, cd);
        do_access(32'h3000_0000, 32'h0, 4'h0, 1'b0, rd, lat, ra);
        checks++; if (err_addr !== 32'h2000_0000 || bus_err !== 1'b1)
            begin errors++; $display("FAIL unmapped_sticky: err_addr=%h bus_err=%b want 20000000 1", err_addr, bus_err); end
    endtask

    task automatic test_io();
        logic [31:0] rd, exp_rd; int lat, exp_lat; logic ra; bit cd;
        io_delay_cfg = 5;
        io_data_cfg  = 32'h1234_5678;
        model_access(32'h1000_0004, 32'h0, 4'h0, 5, exp_rd, exp_lat, cd);
        do_access(32'h1000_0004, 32'h0, 4'h0, 1'b0, rd, lat, ra);
        checks++; if (obs_io_sel !== 1'b1 || obs_io_addr !== 8'h04) begin errors++; $display("FAIL io_drive: sel=%b addr=%h want 1 04", obs_io_sel, obs_io_addr); end
        checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL io_data: got %h want 12345678", rd); end
        checks++; if (lat !== exp_lat) begin errors++; $display("FAIL io_latency: got %0d want %0d", lat, exp_lat); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL io_pulse: ready after=%b want 0", ra); end
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [6];
        logic [31:0] rd, exp_rd; int lat, exp_lat; logic ra; bit cd; logic [3:0] st;
        addrs = '{32'h0000_1FFC, 32'h0000_1FFC, 32'h0000_2000, 32'h1000_00FF, 32'h1000_0100, 32'h0FFF_FFFC};
        io_delay_cfg = 1;
        io_data_cfg  = 32'hA5A5_0F0F;
        for (int i = 0; i < 6; i++) begin
            st = (i == 0) ? 4'hF : 4'h0;
            model_access(addrs[i], 32'h1122_3344, st, 1, exp_rd, exp_lat, cd);
            do_access(addrs[i], 32'h1122_3344, st, 1'b0, rd, lat, ra);
            checks++;
            if (lat !== exp_lat || (cd && rd !== exp_rd) || bus_err !== exp_bus_err || err_addr !== exp_err_addr)
                begin errors++; $display("FAIL boundary_%0d: addr=%h lat=%0d/%0d rd=%h/%h err=%b/%b ea=%h/%h", i, addrs[i],
                                         lat, exp_lat, rd, exp_rd, bus_err, exp_bus_err, err_addr, exp_err_addr); end
        end
    endtask

    task automatic test_io_stall();
        int lat; int hits; logic [31:0] rd;
        io_stall     = 1'b1;
        io_delay_cfg = 0;
        io_data_cfg  = 32'h0BAD_F00D;
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h1000_0008; bus.mem_wdata = '0; bus.mem_wstrb = '0;
        lat = -1; hits = 0; rd = 'x;
`ifdef BUS_TIMEOUT_EN
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.mem_ready) begin lat = c; rd = bus.mem_rdata; break; end
        end
        if (!exp_bus_err) exp_err_addr = 32'h1000_0008;
        exp_bus_err = 1'b1;
        checks++; if (lat !== TIMEOUT_CYC + 1 || io_sel !== 1'b0) begin errors++; $display("FAIL io_timeout_latency: got %0d io_sel=%b want %0d 0", lat, io_sel, TIMEOUT_CYC + 1); end
        checks++; if (rd !== ERR_W || bus_err !== 1'b1 || err_addr !== exp_err_addr)
            begin errors++; $display("FAIL io_timeout_err: rd=%h bus_err=%b ea=%h want deadbeef 1 %h", rd, bus_err, err_addr, exp_err_addr); end
        io_stall = 1'b0;
`else
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (bus.mem_ready) hits++;
        end
        checks++; if (hits !== 0 || io_sel !== 1'b1) begin errors++; $display("FAIL io_stall_wait: ready pulses=%0d io_sel=%b want 0 1", hits, io_sel); end
        io_stall = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (bus.mem_ready) begin lat = c; rd = bus.mem_rdata; break; end
        end
        checks++; if (lat < 0 || rd !== 32'h0BAD_F00D) begin errors++; $display("FAIL io_stall_release: lat=%0d rd=%h want answer 0badf00d", lat, rd); end
`endif
        bus.mem_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] addr, wd, rd, exp_rd; logic [3:0] st; int lat, exp_lat, dly, kind; logic ra; bit cd, drop;
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            dly  = $urandom_range(0, 6);
            wd   = $urandom;
            st   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            drop = ($urandom_range(0, 3) == 0);
            if (kind <= 1)     addr = 32'($urandom_range(0, 8191));
            else if (kind == 2) addr = 32'h1000_0000 + 32'($urandom_range(0, 255));
            else                addr = 32'h4000_0000 + 32'($urandom_range(0, 32'h0FFF_FFFF));
            io_delay_cfg = dly;
            io_data_cfg  = $urandom;
            model_access(addr, wd, st, dly, exp_rd, exp_lat, cd);
            if (cd) exp_q.push_back(exp_rd);
            do_access(addr, wd, st, drop, rd, lat, ra);
            checks++;
            if (lat !== exp_lat || ra !== 1'b0)
                begin errors++; $display("FAIL rand_%0d_timing: addr=%h lat=%0d want %0d ready after=%b", n, addr, lat, exp_lat, ra); end
            if (cd) begin
                exp_rd = exp_q.pop_front();
                checks++;
                if (rd !== exp_rd) begin errors++; $display("FAIL rand_%0d_data: addr=%h got %h want %h", n, addr, rd, exp_rd); end
            end
            checks++;
            if (bus_err !== exp_bus_err || err_addr !== exp_err_addr)
                begin errors++; $display("FAIL rand_%0d_err: bus_err=%b ea=%h want %b %h", n, bus_err, err_addr, exp_bus_err, exp_err_addr); end
            if (kind <= 1) begin
                checks++;
                if (obs_sram_sel !== 1'b1 || obs_sram_addr !== addr[12:0] || obs_sram_wstrb !== st || obs_io_sel !== 1'b0)
                    begin errors++; $display("FAIL rand_%0d_sram_drive: sel=%b addr=%h st=%h want 1 %h %h", n, obs_sram_sel, obs_sram_addr, obs_sram_wstrb, addr[12:0], st); end
            end else if (kind == 2) begin
                checks++;
                if (obs_io_sel !== 1'b1 || obs_io_addr !== addr[7:0] || obs_io_wstrb !== st || obs_io_wdata !== wd || obs_sram_sel !== 1'b0)
                    begin errors++; $display("FAIL rand_%0d_io_drive: sel=%b addr=%h st=%h wd=%h want 1 %h %h %h", n, obs_io_sel, obs_io_addr, obs_io_wstrb, obs_io_wdata, addr[7:0], st, wd); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int hits; logic [31:0] rd, exp_rd; int lat, exp_lat; logic ra; bit cd;
        bus.mem_valid = 1'b1; bus.mem_addr = 32'h10; bus.mem_wdata = '0; bus.mem_wstrb = '0;
        @(posedge clk); #1;
        checks++; if (sram_sel !== 1'b1) begin errors++; $display("FAIL mid_reset_setup: sram_sel=%b want 1", sram_sel); end
        resetn = 1'b0;
        bus.mem_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({bus.mem_ready, bus.mem_rdata, sram_sel, sram_wstrb, sram_addr, sram_wdata, io_sel,
             io_wstrb, io_addr, io_wdata, bus_err, err_addr, dbg_state} !== '0)
            begin errors++; $display("FAIL mid_reset_outputs: sel=%b rdata=%h err=%b ea=%h state=%0d want all 0",
                                     sram_sel, bus.mem_rdata, bus_err, err_addr, dbg_state); end
        exp_bus_err = 1'b0; exp_err_addr = '0;
        hits = 0;
        for (int c = 0; c < 2; c++) begin @(posedge clk); #1; if (bus.mem_ready) hits++; end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (bus.mem_ready) hits++; end
        checks++; if (hits !== 0) begin errors++; $display("FAIL mid_reset_no_ready: pulses=%0d want 0", hits); end
        model_access(32'h10, 32'h0, 4'h0, 0, exp_rd, exp_lat, cd);
        do_access(32'h10, 32'h0, 4'h0, 1'b0, rd, lat, ra);
        checks++; if (lat !== 3 || rd !== exp_rd || ra !== 1'b0)
            begin errors++; $display("FAIL mid_reset_fresh_read: lat=%0d rd=%h want 3 %h", lat, rd, exp_rd); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < 2048; i++) begin sram_mem[i] = '0; ref_mem[i] = '0; end
        bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
        resetn = 1'b0;
        test_reset();
        test_sram_write_read();
        test_byte_write();
        test_unmapped();
        test_io();
        test_boundaries();
        test_io_stall();
        test_random();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_decoder.md
Name: mem_bus_decoder

Overview:
- Sits between the picorv32 native memory interface and the on-chip SRAM (8 KiB, 1-cycle registered-ready) plus one MMIO peripheral slot.
- Decodes each CPU request, drives registered select/address/data to exactly one target, captures read data and returns a single-cycle mem_ready pulse.
- Unmapped accesses and stalled peripheral accesses complete with an error word, so the CPU never hangs.

Parameters:
- SRAM_ADDRWIDTH, 13, byte-address width of SRAM. SRAM region is 0 .. 2**SRAM_ADDRWIDTH-1.
- IO_BASE, 32'h1000_0000, base of the 256-byte MMIO region.
- ERR_WORD, 32'hDEAD_BEEF, read data returned on any error completion.
- TIMEOUT_CYCLES, 16, MMIO wait limit. Only used with BUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- mem_valid  in  1  CPU request valid
- mem_ready  out  1  CPU request complete, one-cycle pulse
- mem_addr  in  32  CPU byte address
- mem_wdata  in  32  CPU write data
- mem_wstrb  in  4  CPU byte strobes. 0 means read.
- mem_rdata  out  32  read data, valid while mem_ready=1
- sram_sel  out  1  SRAM select
- sram_wstrb  out  4  SRAM byte strobes
- sram_addr  out  SRAM_ADDRWIDTH  SRAM byte address
- sram_wdata  out  32  SRAM write data
- sram_ready  in  1  SRAM ready (registered copy of sram_sel)
- sram_rdata  in  32  SRAM read data
- io_sel  out  1  MMIO select
- io_wstrb  out  4  MMIO strobes
- io_addr  out  8  MMIO offset
- io_wdata  out  32  MMIO write data
- io_ready  in  1  MMIO done
- io_rdata  in  32  MMIO read data
- bus_err  out  1  sticky error flag
- err_addr  out  32  address of first error

Behaviour:
- Reset: clk is the clock; reset is resetn, synchronous, active-low.
  - While resetn=0: FSM to IDLE; all outputs 0, including mem_rdata, bus_err, err_addr, the selects and all target-side buses. Reset mid-transaction aborts it silently, with no mem_ready.
- All outputs are registered.
- FSM states: IDLE, SRAM_WAIT, IO_WAIT, RESP.
- IDLE, when mem_valid=1:
  - SRAM hit: mem_addr[31:SRAM_ADDRWIDTH]==0. Latch addr/wdata/wstrb onto the sram_* outputs, set sram_sel=1, go to SRAM_WAIT.
  - IO hit: mem_addr[31:8]==IO_BASE[31:8]. Latch onto the io_* outputs, set io_sel=1, clear the timeout counter, go to IO_WAIT.
  - Otherwise: mem_rdata<=ERR_WORD, bus_err<=1; err_addr<=mem_addr only if bus_err was 0. Go to RESP.
- SRAM_WAIT:
  - When sram_ready=1: mem_rdata<=sram_rdata (also on writes), sram_sel<=0, sram_wstrb<=0, go to RESP.
  - sram_ready is sampled only in this state.
  - The first SRAM_WAIT cycle always sees sram_ready=0, because sel was low in the prior cycle.
- IO_WAIT:
  - When io_ready=1: mem_rdata<=io_rdata, io_sel<=0, io_wstrb<=0, go to RESP.
  - The counter increments each cycle without io_ready.
- RESP: mem_ready=1 for exactly this cycle, then go to IDLE.
  - RESP also absorbs the stale sram_ready that follows sel deassert, so no target is selected within 2 cycles of the previous deselect.
- Latency from mem_valid seen in IDLE:
  - SRAM read/write: mem_ready in the 4th cycle (3 clocks after the IDLE cycle).
  - Unmapped: mem_ready in the 3rd cycle.
  - IO: 3 + (io_ready delay) cycles.
- During SRAM_WAIT the SRAM may rewrite the same word twice with identical data. This is harmless.
- mem_addr[1:0] is forwarded unchanged. No alignment checking.
- mem_valid dropping mid-transaction is ignored: the transaction completes and mem_ready still pulses.
- sram_ready or io_ready asserting in IDLE or RESP is ignored.
- bus_err clears only on reset.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - In IO_WAIT, if the counter reaches TIMEOUT_CYCLES with io_ready still 0: io_sel<=0, mem_rdata<=ERR_WORD, bus_err/err_addr updated as for an unmapped access, go to RESP.
  - io_ready arriving in the same cycle as the limit wins: a normal completion occurs.
- Not defined: no counter logic exists, and IO_WAIT waits indefinitely for io_ready.

Test Plan:
- SRAM write then read: write mem_addr=0x0000_0010, wdata=0xCAFEBABE, wstrb=4'hF, then read the same address.
  - Expected: each mem_ready pulses exactly once, 3 clocks after the request is seen.
  - Expected: sram_addr=13'h010 during the access.
  - Expected: the read returns 0xCAFEBABE and bus_err stays 0.
- Byte write: wstrb=4'b0100, wdata=0x00AA0000 to 0x10, then read 0x10.
  - Expected: the read returns 0xCAAABABE.
- Unmapped access: read 0x2000_0000.
  - Expected: mem_ready 2 clocks later, mem_rdata=0xDEADBEEF, bus_err=1, err_addr=0x2000_0000.
  - Then read 0x3000_0000: err_addr remains 0x2000_0000.
- IO access: read 0x1000_0004 with the model asserting io_ready=1 5 cycles after io_sel, io_rdata=0x12345678.
  - Expected: io_addr=8'h04, mem_rdata=0x12345678, single mem_ready pulse.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=16): IO read with io_ready held 0.
  - Expected: io_sel drops after 16 cycles, mem_ready returns 0xDEADBEEF, bus_err=1.
  - Without the macro: mem_ready stays 0 for 100 cycles.
- Reset mid-access: assert resetn=0 during SRAM_WAIT.
  - Expected: next cycle all outputs are 0 and no mem_ready occurs.
  - A fresh read of 0x10 after reset completes normally in 3 clocks.
